// File: rtl/shared_gate_arbiter_if.sv
// Request/response bundle for shared_gate_arbiter: four packed requesters in,
// one AND result out, plus status.
interface shared_gate_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic [3:0]         req_valid;
   logic [4*WIDTH-1:0] req_a;
   logic [4*WIDTH-1:0] req_b;
   logic [3:0]         req_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_id;
   logic               out_ready;
   logic               busy;
   logic [15:0]        done_cnt;

   modport master (
      output req_valid, req_a, req_b, out_ready,
      input  req_ready, out_valid, out_data, out_id, busy, done_cnt
   );

   modport slave (
      input  req_valid, req_a, req_b, out_ready,
      output req_ready, out_valid, out_data, out_id, busy, done_cnt
   );
endinterface

// File: rtl/shared_gate_arbiter.sv
// Round-robin arbiter over four requesters; the winner's operands are ANDed
// and returned through a valid/ready result port, one transaction at a time.
module shared_gate_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   shared_gate_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         id_q, id_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [1:0]         out_id_q, out_id_d;
   logic [15:0]        done_cnt_q, done_cnt_d;
   logic [3:0]         req_ready;

   logic               found;
   logic [1:0]         win;
   logic [1:0]         idx;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      // Scan upward from ptr_q, wrapping naturally in the 2-bit index.
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < 4; k++) begin
         if (win == 2'(k)) begin
            a_sel = bus.req_a[k*WIDTH +: WIDTH];
            b_sel = bus.req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      done_cnt_d  = done_cnt_q;
      req_ready   = '0;
      unique case (state_q)
         StIdle: begin
            // rst_n gate keeps req_ready low while reset is held.
            if (found && rst_n) begin
               req_ready[win] = 1'b1;
               a_d            = a_sel;
               b_d            = b_sel;
               id_d           = win;
               ptr_d          = win + 2'd1;
               state_d        = StExec;
            end
         end
         StExec: begin
            out_data_d  = a_q & b_q;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + 16'd1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         done_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done_cnt  = done_cnt_q;

endmodule
